// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// bit positions inside the WB and M control bundles, and the default
// wait limit for a memory access.
package mips_pkg;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int M_BRANCH    = 2;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;

   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage controller and the memory.
//   mem_req   : access request, held until mem_ready
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : byte address
//   mem_wdata : store data
//   mem_rdata : load data, valid with mem_ready
//   mem_ready : access complete
interface mem_stage_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register.
//   clk, reset : clock, synchronous active-high reset
//   load_en    : capture this cycle
//   bubble     : capture all-zero instead of the inputs
//   wb, rdata, alu, rdrt       : values to capture
//   wb_q, rdata_q, alu_q, rdrt_q : registered MEM/WB fields
module memwb_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_en,
   input  logic        bubble,
   input  logic [1:0]  wb,
   input  logic [31:0] rdata,
   input  logic [31:0] alu,
   input  logic [4:0]  rdrt,
   output logic [1:0]  wb_q,
   output logic [31:0] rdata_q,
   output logic [31:0] alu_q,
   output logic [4:0]  rdrt_q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_q    <= '0;
         rdata_q <= '0;
         alu_q   <= '0;
         rdrt_q  <= '0;
      end else if (load_en) begin
         if (bubble) begin
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            rdrt_q  <= '0;
         end else begin
            wb_q    <= {wb[WB_REGWRITE], wb[WB_MEMTOREG]};
            rdata_q <= rdata;
            alu_q   <= alu;
            rdrt_q  <= rdrt;
         end
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: sequences data-memory accesses, stalls the
// front of the pipeline while a load/store is outstanding, flags
// misaligned or timed-out accesses, and feeds the MEM/WB register.
//   clk, reset          : clock, synchronous active-high reset
//   WB, M               : EX/MEM control bundles
//   ALURes, DataIn      : ALU result / address, store data
//   RdRt, zero          : destination register, ALU zero flag
//   mem                 : data-memory bus (master side)
//   stall, PCSrc, err   : pipeline freeze, branch taken, sticky fault
//   WBOut, ReadData, ALUOut, RdRtOut : registered MEM/WB fields
//
// state  | meaning
// IDLE   | no access in flight; non-memory ops pass straight through
// ACCESS | request on the bus, waiting for mem_ready or the wait limit
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  WB,
   input  logic [2:0]  M,
   input  logic [31:0] ALURes,
   input  logic [31:0] DataIn,
   input  logic [4:0]  RdRt,
   input  logic        zero,
   mem_stage_ctrl_if.master mem,
   output logic        stall,
   output logic        PCSrc,
   output logic        err,
   output logic [1:0]  WBOut,
   output logic [31:0] ReadData,
   output logic [31:0] ALUOut,
   output logic [4:0]  RdRtOut
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          cnt_tc;
   logic          access, is_read, aligned;
   logic          bubble, err_set, rd_sel;
   logic          req_c, we_c;
   logic [31:0]   addr_c, wdata_c;

   // Both request bits set counts as a write.
   assign access  = M[M_MEMREAD] | M[M_MEMWRITE];
   assign is_read = M[M_MEMREAD] & ~M[M_MEMWRITE];
   assign aligned = (ALURes[1:0] == 2'b00);
   assign cnt_tc  = (cnt == CW'(TIMEOUT - 1));

   assign PCSrc = M[M_BRANCH] & zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (err_set) err <= 1'b1;
         if (state == ACCESS && !mem.mem_ready && !cnt_tc) cnt <= cnt + CW'(1);
         else                                                cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bubble    = 1'b0;
      err_set   = 1'b0;
      rd_sel    = 1'b0;
      req_c     = 1'b0;
      we_c      = 1'b0;
      addr_c    = '0;
      wdata_c   = '0;
      case (state)
         IDLE: begin
            if (access) begin
               bubble = 1'b1;
               if (aligned) begin
                  stall     = 1'b1;
                  state_nxt = ACCESS;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         ACCESS: begin
            req_c   = 1'b1;
            we_c    = M[M_MEMWRITE];
            addr_c  = ALURes;
            wdata_c = DataIn;
            if (mem.mem_ready) begin
               rd_sel    = is_read;
               state_nxt = IDLE;
            end else if (cnt_tc) begin
               // Give up: release the pipeline and retire a bubble.
               bubble    = 1'b1;
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall  = 1'b1;
               bubble = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem.mem_req   = req_c;
   assign mem.mem_we    = we_c;
   assign mem.mem_addr  = addr_c;
   assign mem.mem_wdata = wdata_c;

   // MEM/WB advances every cycle; a held-up instruction shows up as a bubble.
   memwb_reg u_memwb (
      .clk     (clk),
      .reset   (reset),
      .load_en (1'b1),
      .bubble  (bubble),
      .wb      (WB),
      .rdata   (rd_sel ? mem.mem_rdata : 32'h0),
      .alu     (ALURes),
      .rdrt    (RdRt),
      .wb_q    (WBOut),
      .rdata_q (ReadData),
      .alu_q   (ALUOut),
      .rdrt_q  (RdRtOut)
   );

endmodule
